// File: rtl/iic_req_arbiter.sv
// Round-robin arbiter sharing one IIC master between several requesters.
// Optional absolute priority for requester 0 (the power-up init sequencer).
// One master transaction per grant, tracked through m_busy, with a timeout
// and an enforced idle gap between consecutive transactions.
module iic_req_arbiter #(
  parameter int NREQ       = 3,
  parameter int PRIO0      = 1,
  parameter int TMO_CYCLES = 2_000_000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 m_start,
  output logic [31:0]          m_wdata,
  input  logic                 m_busy,
  input  logic [7:0]           m_rdata
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   gnt_q;
  logic [IW-1:0]   ptr_q;
  logic [TW-1:0]   tmr_q;
  logic [GW-1:0]   gap_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic            start_q;
  logic [7:0]      rdata_q;
  logic [31:0]     wdata_q;

  logic [IW-1:0]   gnt_d;
  logic            gnt_vld_d;
  logic [31:0]     gnt_word_d;

  // Pick the next winner: scan from ptr upwards with wrap; the lowest scan
  // offset wins, so the loop runs downwards and the last hit is kept.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_v;
    gnt_d     = ptr_q;
    gnt_vld_d = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IW'(idx);
      if (req[idx_v]) begin
        gnt_d     = idx_v;
        gnt_vld_d = 1'b1;
      end
    end
    if (PRIO0 != 0 && req[0]) begin
      gnt_d     = '0;
      gnt_vld_d = 1'b1;
    end
  end

  assign gnt_word_d = req_wdata[{gnt_d, 5'b00000} +: 32];

  // Transaction FSM with registered outputs. The timer holds the number of
  // cycles elapsed since the m_start cycle, so it is loaded with 1 on
  // leaving ISSUE and the timeout fires when it would reach TMO_CYCLES.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!m_busy && gnt_vld_d) begin
            gnt_q   <= gnt_d;
            wdata_q <= gnt_word_d;
            ack_q   <= NREQ'(1) << gnt_d;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (gnt_q == IW'(NREQ - 1)) ptr_q <= '0;
          else                        ptr_q <= gnt_q + IW'(1);
          tmr_q   <= TW'(1);
          state_q <= WAIT_HI;
        end
        WAIT_HI, WAIT_LO: begin
          if (state_q == WAIT_LO && !m_busy) begin
            done_q  <= NREQ'(1) << gnt_q;
            rdata_q <= m_rdata;
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (tmr_q == TW'(TMO_CYCLES - 1)) begin
            done_q  <= NREQ'(1) << gnt_q;
            err_q   <= 1'b1;
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            tmr_q <= tmr_q + TW'(1);
            if (state_q == WAIT_HI && m_busy) state_q <= WAIT_LO;
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= IDLE;
          else                              gap_q   <= gap_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign m_start = start_q;
  assign m_wdata = wdata_q;

endmodule

// File: doc/iic_req_arbiter.md
Name: iic_req_arbiter

Overview:
Shares the single IIC master (start pulse / 32-bit {dev_addr, reg_addr, data} word / busy / 8-bit read data) between several requesters: the power-up config sequencer, runtime register writers and status pollers. It selects one request at a time by round-robin, with optional absolute priority for requester 0 (init sequencer). It issues exactly one master transaction per grant, tracks it via busy, and returns done, read data and a timeout error to the winner. It sits between the requester blocks and the IIC master instance.

Parameters:
NREQ, 3, number of requesters (2..8); index 0 = init sequencer
PRIO0, 1, 1 = requester 0 always wins when requesting; 0 = pure round-robin
TMO_CYCLES, 2_000_000, max sclk cycles from m_start to busy falling before timeout
GAP_CYCLES, 16, idle sclk cycles enforced between transactions

Ports:
sclk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until ack
req_wdata  in  NREQ*32  request words, requester i at [32*i+31:32*i]
ack  out  NREQ  one-hot 1-cycle pulse: request accepted, issued to master
done  out  NREQ  one-hot 1-cycle pulse: transaction finished (or timed out)
err  out  1  1-cycle pulse coincident with done when transaction timed out
rdata  out  8  read byte of the last finished transaction, held until next done
m_start  out  1  1-cycle start pulse to IIC master
m_wdata  out  32  word to IIC master, stable from m_start until done
m_busy  in  1  IIC master busy
m_rdata  in  8  IIC master read data, valid when busy falls

Behaviour:
- Reset (async, any state): state IDLE, ack/done/err/m_start = 0, m_wdata = 0, rdata = 0, rr pointer = 0, timers = 0.
- Clock sclk; reset s_rst_n, asynchronous, active-low.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP.
- IDLE: arbitrate only when m_busy = 0 and req != 0. Winner: if PRIO0=1 and req[0]=1 -> 0; else first set bit scanning ptr, ptr+1, ... wrapping at NREQ-1 -> 0. Register grant index and req_wdata slice into m_wdata; go ISSUE. m_busy = 1 in IDLE (e.g. after reset release) blocks all grants.
- ISSUE (1 cycle): m_start = 1, ack[gnt] = 1; ptr <= gnt+1 (wrap to 0 at NREQ); timer cleared; go WAIT_HI. Latency req seen in IDLE -> m_start/ack = 1 cycle.
- WAIT_HI: wait m_busy = 1 -> WAIT_LO. WAIT_LO: wait m_busy = 0 -> done[gnt] = 1, rdata <= m_rdata, err = 0, go GAP.
- Timer counts every cycle in WAIT_HI/WAIT_LO; reaching TMO_CYCLES -> done[gnt] = 1, err = 1, rdata unchanged, go GAP.
- GAP: count GAP_CYCLES cycles, then IDLE. GAP_CYCLES = 0 -> direct IDLE next cycle.
- Requester rules: req and its wdata slice held stable until ack; req dropped before ack -> no transaction for it. req still high in the cycle after ack counts as a new request.
- Requests arriving during ISSUE..GAP wait; none are lost while req held.
- Simultaneous requests: exactly one ack per arbitration; at most one of ack/done bits set per cycle; ack and done never in the same cycle.
- m_wdata changes only in IDLE when a grant is taken.

Test Plan:
- Single request: req=3'b010, req_wdata[63:32]=32'h78300a56; master busy 1 cycle after start for 100 cycles, m_rdata=8'h56 -> m_start and ack=3'b010 one cycle after req, m_wdata=32'h78300a56, done=3'b010 when busy falls, rdata=8'h56, err=0.
- Round-robin, PRIO0=0: req=3'b111 held throughout -> ack order 0,1,2,0; consecutive m_start separated by >= GAP_CYCLES idle cycles after done.
- Priority, PRIO0=1: req=3'b110 issuing to 1, req[0] raised mid-transaction -> next grant is 0, then 2.
- Timeout: TMO_CYCLES=50, m_busy held 0 after m_start -> done[gnt] and err=1 exactly 50 cycles after m_start; rdata unchanged; next request then served.
- Busy at reset release: m_busy=1 for 20 cycles after reset, req=3'b001 -> no m_start until m_busy=0, then m_start the following cycle.
- Reset mid-transaction: assert s_rst_n=0 in WAIT_LO -> all outputs 0 immediately; after release with req=3'b100, grant goes to 2 (ptr=0 scan).
